toupper_seq_ctrl: RTL and testbench
===================================

Name: toupper_seq_ctrl

Overview:
Sequencing controller for the byte-wide ASCII to-uppercase datapath. Accepts a NUL-terminated character string over a valid/ready stream and converts lowercase letters to uppercase. Buffers converted bytes in a small FIFO and emits them over a valid/ready stream. Reports string length, conversion count and completion to the host sequencer.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
CNT_W, 8, width of the length and conversion counters.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  begin a new string; sampled only in IDLE.
in_valid  in  1  input byte valid.
in_ready  out  1  controller can accept an input byte.
in_data  in  8  input ASCII byte.
out_valid  out  1  converted byte available.
out_ready  in  1  downstream accepts the output byte.
out_data  out  8  converted ASCII byte.
out_last  out  1  marks the NUL terminator byte on the output.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse when the string has fully drained.
len_count  out  CNT_W  bytes accepted, excluding NUL; saturating.
conv_count  out  CNT_W  bytes changed by conversion; saturating.

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO emptied; all outputs 0, including in_ready, out_valid, out_data, out_last, busy, done and both counters.
- Conversion rule: if in_data is in 0x61..0x7A, write in_data-0x20; otherwise write in_data unchanged. Conversion is applied at FIFO write time.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0 and busy=0.
  - start=1 moves to RUN and clears len_count and conv_count in the same edge.
  - Counters otherwise hold their last values, so they stay readable after DONE.
- RUN:
  - in_ready = !full.
  - An input transfer occurs on in_valid & in_ready and pushes {last,byte}, with last=(in_data==0x00).
  - A non-NUL accept increments len_count. It also increments conv_count if the byte was in 0x61..0x7A.
  - Both counters saturate at 2^CNT_W-1.
  - Accepting NUL moves to DRAIN; in_ready is 0 from the next cycle.
- DRAIN:
  - in_ready=0.
  - When the NUL entry is popped (out_valid & out_ready & out_last), go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
- start while not in IDLE is ignored.
- Output side:
  - out_valid = FIFO not empty, in any state.
  - out_data and out_last come from the FIFO head.
  - Head values stay stable while out_valid=1 and out_ready=0.
  - A pop occurs on out_valid & out_ready.
- Latency: a byte accepted at edge N into an empty FIFO shows out_valid=1 after edge N and can be popped at edge N+1. There is no same-cycle combinational pass-through.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle. in_ready rises in the cycle after the pop.
- Simultaneous push and pop when not full: both occur and the occupancy is unchanged.
- Pointers are log2(DEPTH) bits plus one wrap bit. full and empty are derived from pointer compare and must wrap correctly over many passes.
- Reset asserted mid-string: the FIFO is discarded, no done pulse is produced, and the FSM returns to IDLE immediately.

Test Plan:
- Basic string: start, then send 0x68 0x69 0x21 0x00 with out_ready=1.
  - Required output: 0x48 0x49 0x21 0x00, with out_last only on 0x00.
  - Required counters: len_count=3, conv_count=2.
  - Required timing: done pulses once after the last pop, and busy is low afterwards.
- Range edges: send 0x60 0x61 0x7A 0x7B 0x40 0x5A 0x00.
  - Required output: 0x60 0x41 0x5A 0x7B 0x40 0x5A 0x00.
  - Required counters: conv_count=2, len_count=6.
- Backpressure with DEPTH=4: out_ready=0, offer 0x61 0x62 0x63 0x64 0x65.
  - in_ready drops after the 4th accept, and out_data holds 0x41 stable.
  - Raise out_ready: 0x45 enters only after the first pop, and order is preserved: 0x41 0x42 0x43 0x44 0x45.
- Wrap-around: a 20-byte string of 0x7A plus 0x00, with out_ready toggling every cycle.
  - Required output: 20×0x5A then 0x00, with no loss or duplication.
  - Required counters: len_count=20, conv_count=20.
- Saturation and idle checks with CNT_W=2: send 0x61 0x62 0x63 0x64 0x00.
  - Required counters: len_count=3, conv_count=3.
  - in_ready stays 0 in IDLE before start.
  - A start pulse during RUN has no effect.
- Reset mid-operation: after 2 bytes accepted and 1 pending in the FIFO, pulse rst asynchronously between clock edges.
  - All outputs go to 0 immediately and state is IDLE.
  - The next start/string "ab\0" gives 0x41 0x42 0x00.

Source files
------------

// File: rtl/toupper_seq_ctrl_if.sv
// Byte stream bundle for the to-uppercase controller: input side and FIFO output side.
// The slave modport is the controller's view; the master modport is the host's view.
interface toupper_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/toupper_seq_ctrl.sv
// NUL-terminated string uppercaser: bytes are converted as they enter the FIFO and show at the output
// one cycle after they are accepted. in_ready follows !full only; a pop frees space from the next cycle.
module toupper_seq_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    toupper_seq_ctrl_if.slave    bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     len_count,
    output logic [CNT_W-1:0]     conv_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [8:0]  mem [DEPTH];
    logic [8:0]  head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        is_lower;
    logic        in_last;
    logic [7:0]  conv_byte;

    // The extra wrap bit separates full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign is_lower  = (bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A);
    assign conv_byte = is_lower ? (bus.in_data - 8'h20) : bus.in_data;
    assign in_last   = (bus.in_data == 8'h00);

    assign bus.in_ready = (state == RUN) && !full;
    assign push         = bus.in_valid && bus.in_ready;

    // Head is gated so a stale entry never leaks out while the FIFO is empty.
    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 8'h00 : head[7:0];
    assign bus.out_last  = !empty && head[8];
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, conv_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_count  <= '0;
            conv_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        len_count  <= '0;
                        conv_count <= '0;
                    end
                end
                RUN: begin
                    if (push) begin
                        if (in_last) begin
                            state <= DRAIN;
                        end else begin
                            if (len_count != CNT_MAX) len_count <= len_count + CNT_W'(1);
                            if (is_lower && conv_count != CNT_MAX) conv_count <= conv_count + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && bus.out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_toupper_seq_ctrl.sv
// Directed bench: vector table for conversion strings plus hand sequences for backpressure, wrap, saturation, reset.
module tb_toupper_seq_ctrl;
    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
        logic       dlast;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] len_count;
    logic [7:0] conv_count;
    logic       sat_start;
    logic       s_busy;
    logic       s_done;
    logic [1:0] s_len;
    logic [1:0] s_conv;

    int n_total = 0;
    int n_pass  = 0;

    toupper_seq_ctrl_if bus ();
    toupper_seq_ctrl_if s_bus ();

    toupper_seq_ctrl #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .len_count(len_count), .conv_count(conv_count)
    );

    toupper_seq_ctrl #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(sat_start), .bus(s_bus),
        .busy(s_busy), .done(s_done), .len_count(s_len), .conv_count(s_conv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives the main DUT one cycle at a time; mode 0 = always ready, 1 = toggling, 2 = never ready.
    task automatic pump(input bq_t src, input int mode, input bit poke, output bq_t od, output bq_t ol,
                        output int ndone);
        int idx = 0;
        int cyc = 0;
        int after = 0;
        bit acc;
        od = {};
        ol = {};
        ndone = 0;
        while (cyc < 400 && after < 3) begin
            bus.in_valid  = (idx < src.size());
            bus.in_data   = (idx < src.size()) ? src[idx] : 8'h00;
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'b0;
            start         = poke && (cyc == 2);
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                od.push_back(bus.out_data);
                ol.push_back(bus.out_last);
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (done) ndone++;
            if (ndone > 0) after++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        start         = 1'b0;
    endtask

    task automatic run_str(input bq_t src, input int mode, input bit poke, output bq_t od, output bq_t ol,
                           output int ndone);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pump(src, mode, poke, od, ol, ndone);
    endtask

    initial begin
        vec_t       tbl [11];
        int         exp_len [2];
        int         exp_conv [2];
        logic [7:0] bp [5];
        logic [7:0] satv [5];
        bq_t        src;
        bq_t        od;
        bq_t        ol;
        int         nd;
        int         lo;
        int         hi;
        int         idx;
        int         unstable;
        bit         acc;
        bit         sdone;
        logic [7:0] first;

        tbl = '{
            '{8'h68, 8'h48, 1'b0}, '{8'h69, 8'h49, 1'b0}, '{8'h21, 8'h21, 1'b0}, '{8'h00, 8'h00, 1'b1},
            '{8'h60, 8'h60, 1'b0}, '{8'h61, 8'h41, 1'b0}, '{8'h7A, 8'h5A, 1'b0}, '{8'h7B, 8'h7B, 1'b0},
            '{8'h40, 8'h40, 1'b0}, '{8'h5A, 8'h5A, 1'b0}, '{8'h00, 8'h00, 1'b1}
        };
        exp_len  = '{3, 6};
        exp_conv = '{2, 2};
        bp       = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        satv     = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h00};

        rst = 1'b1;
        start = 1'b0;
        sat_start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        s_bus.in_valid = 1'b0; s_bus.in_data = 8'h00; s_bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, busy, done, len_count, conv_count}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", bus.in_ready, 0);
        chk("idle_busy", busy, 0);

        // Conversion strings from the vector table; the first also pokes start mid-RUN.
        for (int g = 0; g < 2; g++) begin
            lo = (g == 0) ? 0 : 4;
            hi = (g == 0) ? 4 : 11;
            src = {};
            for (int i = lo; i < hi; i++) src.push_back(tbl[i].din);
            run_str(src, 0, (g == 0), od, ol, nd);
            chk($sformatf("g%0d_count", g), od.size(), hi - lo);
            for (int i = lo; i < hi; i++) begin
                if (i - lo < od.size()) begin
                    chk($sformatf("g%0d_data%0d", g, i - lo), od[i-lo], tbl[i].dout);
                    chk($sformatf("g%0d_last%0d", g, i - lo), ol[i-lo], tbl[i].dlast);
                end
            end
            chk($sformatf("g%0d_len", g), len_count, exp_len[g]);
            chk($sformatf("g%0d_conv", g), conv_count, exp_conv[g]);
            chk($sformatf("g%0d_done_pulses", g), nd, 1);
            chk($sformatf("g%0d_busy_after", g), busy, 0);
        end

        // Backpressure: fill the 4-entry FIFO, then a single pop while still full.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        unstable = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp[idx];
            #1;
            acc = bus.in_ready;
            if (bus.out_valid && bus.out_data != 8'h41) unstable++;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_accepts", idx, 4);
        chk("bp_in_ready_full", bus.in_ready, 0);
        chk("bp_head_stable", unstable, 0);
        chk("bp_head", bus.out_data, 8'h41);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_full_pop_in_ready", bus.in_ready, 0);
        first = bus.out_data;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_in_ready_after_pop", bus.in_ready, 1);
        src = {8'h65, 8'h00};
        pump(src, 0, 1'b0, od, ol, nd);
        od.push_front(first);
        chk("bp_count", od.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < od.size()) chk($sformatf("bp_order%0d", i), od[i], (i < 5) ? (8'h41 + i) : 8'h00);
        end
        chk("bp_len", len_count, 5);

        // Wrap-around with toggling out_ready.
        src = {};
        for (int i = 0; i < 20; i++) src.push_back(8'h7A);
        src.push_back(8'h00);
        run_str(src, 1, 1'b0, od, ol, nd);
        chk("wrap_count", od.size(), 21);
        for (int i = 0; i < 21; i++) begin
            if (i < od.size()) begin
                chk($sformatf("wrap_data%0d", i), od[i], (i < 20) ? 8'h5A : 8'h00);
                chk($sformatf("wrap_last%0d", i), ol[i], (i == 20));
            end
        end
        chk("wrap_len", len_count, 20);
        chk("wrap_conv", conv_count, 20);
        chk("wrap_done_pulses", nd, 1);

        // Saturation on the 2-bit counter instance.
        chk("sat_idle_in_ready", s_bus.in_ready, 0);
        sat_start = 1'b1;
        @(posedge clk); #1;
        sat_start = 1'b0;
        s_bus.out_ready = 1'b1;
        idx = 0;
        sdone = 1'b0;
        for (int c = 0; c < 60 && !sdone; c++) begin
            s_bus.in_valid = (idx < 5);
            s_bus.in_data  = (idx < 5) ? satv[idx] : 8'h00;
            #1;
            acc = s_bus.in_valid && s_bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (s_done) sdone = 1'b1;
        end
        s_bus.in_valid = 1'b0;
        s_bus.out_ready = 1'b0;
        chk("sat_done", sdone, 1);
        chk("sat_len", s_len, 3);
        chk("sat_conv", s_conv, 3);

        // Asynchronous reset with one byte still in the FIFO.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h61;
        repeat (2) begin @(posedge clk); #1; end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("mid_pending", {bus.out_valid, len_count}, {1'b1, 8'd2});
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, busy, done, len_count, conv_count}, 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_idle", {bus.in_ready, bus.out_valid, busy, done}, 0);
        src = {8'h61, 8'h62, 8'h00};
        run_str(src, 0, 1'b0, od, ol, nd);
        chk("post_rst_count", od.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < od.size()) chk($sformatf("post_rst_data%0d", i), od[i], (i == 0) ? 8'h41 : (i == 1) ? 8'h42 : 8'h00);
        end
        chk("post_rst_done_pulses", nd, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
